if_prefetch_queue: RTL
======================

Name: if_prefetch_queue

Overview:
- Parametrised successor to the RV32I instruction-fetch stage.
- Decouples PC generation from instruction memory with a request/response IMEM handshake, in-order outstanding requests and a prefetch instruction queue.
- Handles EX branch / ID jump redirects by flushing the queue and discarding stale in-flight responses.
- Sits between the IMEM port and the ID stage; presents PC/instruction pairs with a valid flag.

Parameters:
- XLEN, 32, instruction/PC width
- QUEUE_DEPTH, 4, instruction-queue entries and the maximum of in-flight requests plus queued instructions (power of 2, >=2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- Clk  input  1  clock, all state on rising edge
- Reset  input  1  asynchronous, active-high reset
- IMEM_req_valid  output  1  fetch request valid
- IMEM_req_ready  input  1  IMEM accepts request
- IMEM_addr  output  XLEN  fetch address, word aligned
- IMEM_rsp_valid  input  1  response valid, in request order, never back-pressured
- IMEM_rsp_data  input  32  fetched instruction
- EX_PC_Branch  input  1  taken branch redirect
- EX_PC_Branch_dest  input  XLEN  branch target
- ID_Jump  input  1  jump redirect
- ID_PC_dest  input  XLEN  jump target
- IF_Stall  input  1  ID not accepting
- IF_Flush  input  1  kill the instruction currently presented
- IF_valid  output  1  IF_PC/IF_Instruction valid
- IF_PC  output  XLEN  PC of presented instruction
- IF_Instruction  output  32  presented instruction, 0 when not valid

Behaviour:
- Reset, asynchronous: fetch_pc=RESET_PC, pc FIFO, instruction queue and drop_cnt cleared; IF_valid=0, IF_PC=0, IF_Instruction=0, IMEM_req_valid=0. IMEM is reset together with this block, so no stale responses exist after reset.
- Issue: IMEM_req_valid = !redirect && (inflight + iq_count) < QUEUE_DEPTH. IMEM_addr=fetch_pc. On accept: push fetch_pc to pc FIFO, fetch_pc += 4 (wraps modulo 2^XLEN).
- Response: if drop_cnt>0, discard and decrement. Otherwise pop pc FIFO and push {pc, data} into the instruction queue; the entry is visible at the outputs the next cycle. No overflow is possible by the credit rule.
- Output: the head of the instruction queue drives IF_PC/IF_Instruction. IF_valid = !empty && !IF_Flush. When IF_valid=0, IF_Instruction=0 and IF_PC holds its last value.
- Pop: head is removed when !empty && !IF_Stall. With IF_Flush=1 the head is removed without delivery. IF_Stall=1 holds the head regardless of IF_Flush.
- Redirect (redirect = EX_PC_Branch | ID_Jump):
  - Target is EX_PC_Branch_dest if EX_PC_Branch, else ID_PC_dest (EX has priority).
  - Target low 2 bits are forced to 0.
  - fetch_pc <= target; instruction queue and pc FIFO cleared.
  - drop_cnt <= inflight − (response arriving this cycle ? 1 : 0); a response in the redirect cycle is discarded.
  - No request is issued in the redirect cycle; the target request is issued at N+1 at the earliest.
- Redirect latency: redirect at cycle N, IMEM responding in 1 cycle -> target request at N+1, response at N+2, IF_valid with IF_PC=target at N+3.
- Redirect in back-to-back cycles: the last one wins; drop_cnt is recomputed each time.
- inflight = pc FIFO count + drop_cnt; drop_cnt width is clog2(QUEUE_DEPTH)+1.

Optional Feature:
- Macro: IF_PREFETCH_PERF_EN.
- Enabled: adds outputs Perf_fetched and Perf_dropped (32-bit each, reset 0, saturating). Perf_fetched counts instructions delivered (IF_valid && !IF_Stall). Perf_dropped counts responses discarded by drop_cnt plus queue entries cleared by redirect or IF_Flush.
- Disabled: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, IMEM 1-cycle, IF_Stall=0 -> requests 0x0,0x4,0x8,...; IF_valid from cycle 3 with IF_PC 0x0,0x4,... and matching data.
- IF_Stall=1 for 10 cycles -> at most QUEUE_DEPTH=4 outstanding+queued, IMEM_req_valid drops, head held stable; release delivers in order with no loss.
- EX_PC_Branch=1 with dest 0x100 while 2 requests are in flight -> both responses discarded, first valid IF_PC=0x100 three cycles later.
- EX_PC_Branch (0x200) and ID_Jump (0x300) in the same cycle -> fetch resumes at 0x200.
- ID_PC_dest=0x103 -> IMEM_addr=0x100. IF_Flush=1 with IF_Stall=0 -> IF_valid=0, IF_Instruction=0, head dropped, next entry presented.
- Assert Reset mid-stream with a full queue -> outputs zero immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_queue_if.sv
// Fetch-stage bundle: IMEM request/response handshake plus the ID-side
// redirect, stall/flush and presented-instruction signals.
// Optional: IF_PREFETCH_PERF_EN adds the Perf_fetched/Perf_dropped counters.
interface if_prefetch_queue_if #(
    parameter int unsigned XLEN = 32
);
    // IMEM request/response
    logic            IMEM_req_valid;
    logic            IMEM_req_ready;
    logic [XLEN-1:0] IMEM_addr;
    logic            IMEM_rsp_valid;
    logic [31:0]     IMEM_rsp_data;

    // Redirects from later stages
    logic            EX_PC_Branch;
    logic [XLEN-1:0] EX_PC_Branch_dest;
    logic            ID_Jump;
    logic [XLEN-1:0] ID_PC_dest;

    // ID-side presentation
    logic            IF_Stall;
    logic            IF_Flush;
    logic            IF_valid;
    logic [XLEN-1:0] IF_PC;
    logic [31:0]     IF_Instruction;

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0]     Perf_fetched;
    logic [31:0]     Perf_dropped;

    modport master (
        output IMEM_req_valid, IMEM_addr,
        input  IMEM_req_ready, IMEM_rsp_valid, IMEM_rsp_data,
        input  EX_PC_Branch, EX_PC_Branch_dest, ID_Jump, ID_PC_dest,
        input  IF_Stall, IF_Flush,
        output IF_valid, IF_PC, IF_Instruction,
        output Perf_fetched, Perf_dropped
    );

    modport slave (
        input  IMEM_req_valid, IMEM_addr,
        output IMEM_req_ready, IMEM_rsp_valid, IMEM_rsp_data,
        output EX_PC_Branch, EX_PC_Branch_dest, ID_Jump, ID_PC_dest,
        output IF_Stall, IF_Flush,
        input  IF_valid, IF_PC, IF_Instruction,
        input  Perf_fetched, Perf_dropped
    );
`else
    modport master (
        output IMEM_req_valid, IMEM_addr,
        input  IMEM_req_ready, IMEM_rsp_valid, IMEM_rsp_data,
        input  EX_PC_Branch, EX_PC_Branch_dest, ID_Jump, ID_PC_dest,
        input  IF_Stall, IF_Flush,
        output IF_valid, IF_PC, IF_Instruction
    );

    modport slave (
        input  IMEM_req_valid, IMEM_addr,
        output IMEM_req_ready, IMEM_rsp_valid, IMEM_rsp_data,
        output EX_PC_Branch, EX_PC_Branch_dest, ID_Jump, ID_PC_dest,
        output IF_Stall, IF_Flush,
        input  IF_valid, IF_PC, IF_Instruction
    );
`endif

endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage with a prefetch queue.
// Issues in-order IMEM requests under a credit limit of QUEUE_DEPTH
// (in-flight + queued), tracks the PC of each outstanding request in a pc
// FIFO, and queues returned instructions for ID. A redirect clears both
// queues and arms drop_cnt to discard responses still in flight.
// Optional: define IF_PREFETCH_PERF_EN for Perf_fetched/Perf_dropped counters.
module if_prefetch_queue #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    if_prefetch_queue_if.master   bus
);

    localparam int unsigned AW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned IW = 32;

    logic [XLEN-1:0] fetch_pc;

    // PCs of outstanding requests, in issue order
    logic [XLEN-1:0] pcq_mem [QUEUE_DEPTH];
    logic [AW-1:0]   pcq_wr_ptr;
    logic [AW-1:0]   pcq_rd_ptr;
    logic [CW-1:0]   pcq_cnt;

    // Returned {pc, instruction} pairs waiting for ID
    logic [XLEN-1:0] iq_pc_mem  [QUEUE_DEPTH];
    logic [IW-1:0]   iq_ins_mem [QUEUE_DEPTH];
    logic [AW-1:0]   iq_wr_ptr;
    logic [AW-1:0]   iq_rd_ptr;
    logic [CW-1:0]   iq_cnt;

    logic [CW-1:0]   drop_cnt;
    logic [XLEN-1:0] pc_hold;

    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic [SW-1:0]   inflight;
    logic [SW-1:0]   credit_used;
    logic            req_valid;
    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_take;
    logic            iq_empty;
    logic            if_valid;
    logic            iq_pop;

    // Handshake qualifiers, credit check and redirect target selection
    always_comb begin
        redirect        = bus.EX_PC_Branch | bus.ID_Jump;
        redirect_target = bus.EX_PC_Branch ? bus.EX_PC_Branch_dest : bus.ID_PC_dest;
        redirect_target[1:0] = 2'b00;
        inflight        = SW'(pcq_cnt) + SW'(drop_cnt);
        credit_used     = inflight + SW'(iq_cnt);
        req_valid       = !Reset && !redirect && (credit_used < SW'(QUEUE_DEPTH));
        req_fire        = req_valid && bus.IMEM_req_ready;
        rsp_drop        = bus.IMEM_rsp_valid && (drop_cnt != '0);
        rsp_take        = bus.IMEM_rsp_valid && (drop_cnt == '0) && !redirect;
        iq_empty        = (iq_cnt == '0);
        if_valid        = !iq_empty && !bus.IF_Flush;
        iq_pop          = !iq_empty && !bus.IF_Stall;
    end

    assign bus.IMEM_req_valid = req_valid;
    assign bus.IMEM_addr      = fetch_pc;
    assign bus.IF_valid       = if_valid;
    assign bus.IF_PC          = if_valid ? iq_pc_mem[iq_rd_ptr] : pc_hold;
    assign bus.IF_Instruction = if_valid ? iq_ins_mem[iq_rd_ptr] : '0;

    // Fetch PC and pc FIFO pointers; redirect reloads the PC and empties the FIFO
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_pc   <= RESET_PC;
            pcq_wr_ptr <= '0;
            pcq_rd_ptr <= '0;
            pcq_cnt    <= '0;
        end else if (redirect) begin
            fetch_pc   <= redirect_target;
            pcq_wr_ptr <= '0;
            pcq_rd_ptr <= '0;
            pcq_cnt    <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc   <= fetch_pc + XLEN'(4);
                pcq_wr_ptr <= pcq_wr_ptr + AW'(1);
            end
            if (rsp_take) begin
                pcq_rd_ptr <= pcq_rd_ptr + AW'(1);
            end
            pcq_cnt <= pcq_cnt + CW'(req_fire) - CW'(rsp_take);
        end
    end

    // pc FIFO storage
    always_ff @(posedge Clk) begin
        if (req_fire) begin
            pcq_mem[pcq_wr_ptr] <= fetch_pc;
        end
    end

    // Instruction queue storage: pair the response with its request PC
    always_ff @(posedge Clk) begin
        if (rsp_take) begin
            iq_pc_mem[iq_wr_ptr]  <= pcq_mem[pcq_rd_ptr];
            iq_ins_mem[iq_wr_ptr] <= bus.IMEM_rsp_data;
        end
    end

    // Instruction queue pointers; redirect discards everything queued
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            iq_wr_ptr <= '0;
            iq_rd_ptr <= '0;
            iq_cnt    <= '0;
        end else if (redirect) begin
            iq_wr_ptr <= '0;
            iq_rd_ptr <= '0;
            iq_cnt    <= '0;
        end else begin
            if (rsp_take) begin
                iq_wr_ptr <= iq_wr_ptr + AW'(1);
            end
            if (iq_pop) begin
                iq_rd_ptr <= iq_rd_ptr + AW'(1);
            end
            iq_cnt <= iq_cnt + CW'(rsp_take) - CW'(iq_pop);
        end
    end

    // Stale-response counter: a response landing in the redirect cycle is already stale
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            drop_cnt <= '0;
        end else if (redirect) begin
            drop_cnt <= CW'(inflight - SW'(bus.IMEM_rsp_valid));
        end else if (rsp_drop) begin
            drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // Last presented PC, shown while nothing valid is presented
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_hold <= '0;
        end else begin
            pc_hold <= bus.IF_PC;
        end
    end

`ifdef IF_PREFETCH_PERF_EN
    logic        deliver;
    logic [31:0] fetched_inc;
    logic [31:0] dropped_inc;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Per-cycle counter increments
    always_comb begin
        deliver     = if_valid && !bus.IF_Stall;
        fetched_inc = 32'(deliver);
        if (redirect) begin
            dropped_inc = 32'(iq_cnt) - 32'(deliver) + 32'(bus.IMEM_rsp_valid);
        end else begin
            dropped_inc = 32'(rsp_drop) + 32'(iq_pop && bus.IF_Flush);
        end
    end

    // Saturating delivery/drop counters
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.Perf_fetched <= '0;
            bus.Perf_dropped <= '0;
        end else begin
            bus.Perf_fetched <= sat_add(bus.Perf_fetched, fetched_inc);
            bus.Perf_dropped <= sat_add(bus.Perf_dropped, dropped_inc);
        end
    end
`endif

endmodule
